// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets, FSM states,
// bus request/response bundles and the byte-lane merge helper.
package clint_pkg;

  localparam logic [63:0] CLINT_MSIP_OFF     = 64'h0000_0000_0000_0000;
  localparam logic [63:0] CLINT_MTIMECMP_OFF = 64'h0000_0000_0000_4000;
  localparam logic [63:0] CLINT_MTIME_OFF    = 64'h0000_0000_0000_BFF8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } clint_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
  } bus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } bus_resp_t;

  // Merge write data into an existing 64-bit value, one byte lane per strobe bit.
  function automatic logic [63:0] apply_strobe(input logic [63:0] old_v,
                                               input logic [63:0] wr_v,
                                               input logic [7:0]  strb);
    logic [63:0] merged;
    merged = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) begin
        merged[i*8 +: 8] = wr_v[i*8 +: 8];
      end else begin
        merged[i*8 +: 8] = old_v[i*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/clint_timer_sync2.sv
// Generic two-flop synchroniser for a single asynchronous level; resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_ff1;
  logic r_ff2;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff1 <= 1'b0;
      r_ff2 <= 1'b0;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: bus responder holding msip, mtime and mtimecmp, and the
// source of the software, timer and external interrupt lines for the CSR unit.
module clint_timer
  import clint_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  input  logic        ext_irq,
  output logic        swint,
  output logic        trint,
  output logic        exint,
  output logic [63:0] mtime_out
);

  localparam int unsigned    PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

  bus_req_t     w_req;
  bus_resp_t    w_resp;
  clint_state_t r_state;
  clint_state_t w_state_nxt;
  logic [63:0]  w_off;
  logic         w_sel_msip;
  logic         w_sel_cmp;
  logic         w_sel_mtime;
  logic [63:0]  w_rd_val;
  logic         w_wr;
  logic         w_tick;
  logic [PW-1:0] r_presc;
  logic         r_msip;
  logic [63:0]  r_mtime;
  logic [63:0]  r_mtimecmp;
  logic [63:0]  r_rdata;
  logic         r_trint;

  assign w_req = '{valid: req_valid, addr: req_addr, strobe: req_strobe, data: req_data};

  // Word-aligned offset from the CLINT base; anything not matching is unmapped.
  assign w_off       = (w_req.addr & ~64'h0000_0000_0000_0007) - BASE_ADDR;
  assign w_sel_msip  = (w_off == CLINT_MSIP_OFF);
  assign w_sel_cmp   = (w_off == CLINT_MTIMECMP_OFF);
  assign w_sel_mtime = (w_off == CLINT_MTIME_OFF);

  // A write commits on the edge that ends RESP; a zero strobe is a read.
  assign w_wr   = (r_state == RESP) && (w_req.strobe != 8'h00);
  assign w_tick = (r_presc == PRESC_MAX);

  // Read mux; unmapped addresses return zero.
  always_comb begin
    w_rd_val = 64'h0;
    if (w_sel_msip) begin
      w_rd_val = {63'h0, r_msip};
    end else if (w_sel_cmp) begin
      w_rd_val = r_mtimecmp;
    end else if (w_sel_mtime) begin
      w_rd_val = r_mtime;
    end else begin
      w_rd_val = 64'h0;
    end
  end

  // Next-state logic: accept in IDLE, respond for exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_req.valid ? RESP : IDLE;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture read data on entry to RESP (pre-write value); clear it afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= 64'h0;
    end else if ((r_state == IDLE) && w_req.valid) begin
      r_rdata <= w_rd_val;
    end else begin
      r_rdata <= 64'h0;
    end
  end

  // Prescaler free-runs regardless of software writes to mtime.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // mtime: a software write takes precedence and drops a coincident tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mtime <= 64'h0;
    end else if (w_wr && w_sel_mtime) begin
      r_mtime <= apply_strobe(r_mtime, w_req.data, w_req.strobe);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'h1;
    end else begin
      r_mtime <= r_mtime;
    end
  end

  // mtimecmp and msip register bank; msip keeps only bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_msip     <= 1'b0;
    end else begin
      if (w_wr && w_sel_cmp) begin
        r_mtimecmp <= apply_strobe(r_mtimecmp, w_req.data, w_req.strobe);
      end
      if (w_wr && w_sel_msip && w_req.strobe[0]) begin
        r_msip <= w_req.data[0];
      end
    end
  end

  // Timer interrupt: registered unsigned compare, evaluated every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_trint <= 1'b0;
    end else begin
      r_trint <= (r_mtime >= r_mtimecmp);
    end
  end

  sync2 u_ext_sync (
    .clk   (clk),
    .rst_n (reset),
    .i_d   (ext_irq),
    .o_q   (exint)
  );

  assign w_resp = '{addr_ok: (r_state == RESP), data_ok: (r_state == RESP), data: r_rdata};

  assign resp_addr_ok = w_resp.addr_ok;
  assign resp_data_ok = w_resp.data_ok;
  assign resp_data    = w_resp.data;
  assign swint        = r_msip;
  assign trint        = r_trint;
  assign mtime_out    = r_mtime;

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: bus responses are checked against expectations
// queued when each request is driven; interrupt and mtime behaviour checked directly.
module tb_clint_timer;

  localparam logic [63:0] BASE   = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_MSIP = BASE + 64'h0;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_MT   = BASE + 64'hBFF8;
  localparam logic [63:0] A_UNM  = BASE + 64'h100;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [63:0] resp_data;
  logic        ext_irq;
  logic        swint;
  logic        trint;
  logic        exint;
  logic [63:0] mtime_out;

  int n_vec;
  int n_err;

  logic [63:0] q_exp[$];
  string       q_tag[$];
  bit          q_chk[$];
  logic [63:0] mon_exp;
  string       mon_tag;
  bit          mon_chk;

  clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_strobe   (req_strobe),
    .req_data     (req_data),
    .resp_addr_ok (resp_addr_ok),
    .resp_data_ok (resp_data_ok),
    .resp_data    (resp_data),
    .ext_irq      (ext_irq),
    .swint        (swint),
    .trint        (trint),
    .exint        (exint),
    .mtime_out    (mtime_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops one expectation per data_ok pulse.
  always @(negedge clk) begin
    if (resp_data_ok === 1'b1) begin
      if (q_exp.size() == 0) begin
        check_eq("unexpected_resp", {63'h0, resp_data_ok}, 64'h0);
      end else begin
        mon_exp = q_exp.pop_front();
        mon_tag = q_tag.pop_front();
        mon_chk = q_chk.pop_front();
        check_eq({mon_tag, "_aok"}, {63'h0, resp_addr_ok}, 64'h1);
        if (mon_chk) check_eq(mon_tag, resp_data, mon_exp);
      end
    end
  end

  // Advance to just after the n-th next rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus transfer; call just after a rising edge with the DUT idle.
  task automatic bus(input string tag, input logic [63:0] addr, input logic [7:0] strb,
                     input logic [63:0] data, input bit chk, input logic [63:0] exp);
    q_exp.push_back(exp);
    q_tag.push_back(tag);
    q_chk.push_back(chk);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_strobe = strb;
    req_data   = data;
    @(negedge clk);
    check_eq({tag, "_early"}, {63'h0, resp_data_ok}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_lat"}, {63'h0, resp_data_ok}, 64'h1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_strobe = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    req_valid = 1'b0;
    req_addr = 64'h0;
    req_strobe = 8'h00;
    req_data = 64'h0;
    ext_irq = 1'b0;
    tick(3);
    reset = 1'b1;

    // Reset state and 10 idle cycles.
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mtime", mtime_out, 64'd10);
    check_eq("rst_trint", {63'h0, trint}, 64'h0);
    check_eq("rst_swint", {63'h0, swint}, 64'h0);
    check_eq("rst_exint", {63'h0, exint}, 64'h0);
    check_eq("rst_aok", {63'h0, resp_addr_ok}, 64'h0);
    check_eq("rst_dok", {63'h0, resp_data_ok}, 64'h0);
    check_eq("rst_data", resp_data, 64'h0);
    tick(1);

    // Timer compare.
    bus("rd_cmp_rst", A_CMP, 8'h00, 64'h0, 1'b1, ONES);
    bus("wr_cmp20", A_CMP, 8'hFF, 64'h20, 1'b1, ONES);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mtime_out == 64'h20) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("mtime_reach20", {63'h0, found}, 64'h1);
    check_eq("trint_pre", {63'h0, trint}, 64'h0);
    @(negedge clk);
    check_eq("trint_set", {63'h0, trint}, 64'h1);
    tick(1);
    bus("wr_cmp_ones", A_CMP, 8'hFF, ONES, 1'b1, 64'h20);
    @(negedge clk);
    check_eq("trint_hold", {63'h0, trint}, 64'h1);
    @(negedge clk);
    check_eq("trint_clr", {63'h0, trint}, 64'h0);
    tick(1);

    // Partial-lane write to mtimecmp.
    bus("wr_cmp_hi", A_CMP, 8'hF0, 64'h1234_5678_9ABC_DEF0, 1'b1, ONES);
    bus("rd_cmp_hi", A_CMP, 8'h00, 64'h0, 1'b1, 64'h1234_5678_FFFF_FFFF);
    bus("wr_cmp_rest", A_CMP, 8'hFF, ONES, 1'b0, 64'h0);

    // Software interrupt.
    bus("wr_msip", A_MSIP, 8'h0F, 64'h0000_0000_FFFF_FFFF, 1'b1, 64'h0);
    @(negedge clk);
    check_eq("swint_set", {63'h0, swint}, 64'h1);
    tick(1);
    bus("rd_msip", A_MSIP, 8'h00, 64'h0, 1'b1, 64'h1);
    bus("wr_msip0", A_MSIP, 8'h0F, 64'h0, 1'b1, 64'h1);
    @(negedge clk);
    check_eq("swint_clr", {63'h0, swint}, 64'h0);
    tick(1);

    // Unmapped address.
    bus("rd_unm", A_UNM, 8'h00, 64'h0, 1'b1, 64'h0);
    bus("wr_unm", A_UNM, 8'hFF, ONES, 1'b1, 64'h0);
    bus("rd_unm2", A_UNM, 8'h00, 64'h0, 1'b1, 64'h0);
    bus("rd_msip_unm", A_MSIP, 8'h00, 64'h0, 1'b1, 64'h0);
    bus("rd_cmp_unm", A_CMP, 8'h00, 64'h0, 1'b1, ONES);

    // mtime write beats the coincident tick, then counts on.
    bus("wr_mtime", A_MT, 8'hFF, 64'h1000, 1'b0, 64'h0);
    @(negedge clk);
    check_eq("mtime_wr_wins", mtime_out, 64'h1000);
    tick(1);
    bus("rd_mtime", A_MT, 8'h00, 64'h0, 1'b1, 64'h1001);

    // mtime wrap.
    bus("wr_mtime_ones", A_MT, 8'hFF, ONES, 1'b0, 64'h0);
    @(negedge clk);
    check_eq("mtime_ones", mtime_out, ONES);
    @(negedge clk);
    check_eq("mtime_wrap", mtime_out, 64'h0);
    tick(1);

    // External interrupt synchroniser latency.
    ext_irq = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("exint_1cyc", {63'h0, exint}, 64'h0);
    @(negedge clk);
    check_eq("exint_2cyc", {63'h0, exint}, 64'h1);
    tick(1);

    // Reset in the middle of a response.
    bus("wr_msip1", A_MSIP, 8'h01, 64'h1, 1'b0, 64'h0);
    req_valid  = 1'b1;
    req_addr   = A_CMP;
    req_strobe = 8'h00;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_dok", {63'h0, resp_data_ok}, 64'h0);
    check_eq("midrst_aok", {63'h0, resp_addr_ok}, 64'h0);
    check_eq("midrst_swint", {63'h0, swint}, 64'h0);
    check_eq("midrst_mtime", mtime_out, 64'h0);
    check_eq("midrst_exint", {63'h0, exint}, 64'h0);
    req_valid = 1'b0;
    ext_irq   = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);
    bus("rd_msip_post", A_MSIP, 8'h00, 64'h0, 1'b1, 64'h0);
    bus("rd_cmp_post", A_CMP, 8'h00, 64'h0, 1'b1, ONES);
    tick(2);
    check_eq("q_empty", 64'(q_exp.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
